// File: rtl/alias_reduction_pkg.sv
// alias_reduction_pkg: shared widths, FSM encoding and butterfly address helpers
// for the MP3 alias-reduction sequencer.
package alias_reduction_pkg;
  localparam int DATA_W       = 24;
  localparam int COEF_W       = 18;
  localparam int COEF_FRAC    = 17;
  localparam int ADDR_W       = 10;
  localparam int NUM_SB       = 32;
  localparam int LINES_PER_SB = 18;
  localparam int BUTTERFLIES  = 8;
  localparam int SB_W         = $clog2(NUM_SB);
  localparam int IDX_W        = $clog2(BUTTERFLIES);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LO, S_RD_HI, S_CALC, S_WR_LO, S_WR_HI, S_DONE
  } state_e;

  // Lower line of butterfly i: walks downward from the boundary of subband sb
  function automatic int lo_addr(input logic [SB_W-1:0] sb, input logic [IDX_W-1:0] i);
    return LINES_PER_SB * int'(sb) - 1 - int'(i);
  endfunction

  // Upper line of butterfly i: walks upward from the boundary of subband sb
  function automatic int hi_addr(input logic [SB_W-1:0] sb, input logic [IDX_W-1:0] i);
    return LINES_PER_SB * int'(sb) + int'(i);
  endfunction
endpackage

// File: rtl/alias_butterfly.sv
// alias_butterfly: combinational alias-reduction butterfly.
//   lo' = (lo*cs - hi*ca) >>> COEF_FRAC, hi' = (hi*cs + lo*ca) >>> COEF_FRAC
// Sums are kept at full width, shift floors. Define ALIAS_SAT_EN to clamp the
// results to the DATA_W range; otherwise they wrap to the low DATA_W bits.
module alias_butterfly #(
  parameter int DATA_W    = alias_reduction_pkg::DATA_W,
  parameter int COEF_W    = alias_reduction_pkg::COEF_W,
  parameter int COEF_FRAC = alias_reduction_pkg::COEF_FRAC
) (
  input  logic signed [DATA_W-1:0] lo,
  input  logic signed [DATA_W-1:0] hi,
  input  logic signed [COEF_W-1:0] cs,
  input  logic signed [COEF_W-1:0] ca,
  output logic signed [DATA_W-1:0] lo_out,
  output logic signed [DATA_W-1:0] hi_out
);
  localparam int PW = DATA_W + COEF_W;
  localparam int SW = PW + 1;

  logic signed [PW-1:0] lo_cs, hi_ca, hi_cs, lo_ca;
  logic signed [SW-1:0] lo_sum, hi_sum;

  // Full-precision products and sums
  always_comb begin
    lo_cs  = PW'(lo) * PW'(cs);
    hi_ca  = PW'(hi) * PW'(ca);
    hi_cs  = PW'(hi) * PW'(cs);
    lo_ca  = PW'(lo) * PW'(ca);
    lo_sum = SW'(lo_cs) - SW'(hi_ca);
    hi_sum = SW'(hi_cs) + SW'(lo_ca);
  end

`ifdef ALIAS_SAT_EN
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  logic signed [SW-1:0] lo_sh, hi_sh;

  // Floor shift, then clamp into the sample range
  always_comb begin
    lo_sh  = lo_sum >>> COEF_FRAC;
    hi_sh  = hi_sum >>> COEF_FRAC;
    lo_out = (lo_sh > MAX_V) ? MAX_V[DATA_W-1:0] :
             (lo_sh < MIN_V) ? MIN_V[DATA_W-1:0] : lo_sh[DATA_W-1:0];
    hi_out = (hi_sh > MAX_V) ? MAX_V[DATA_W-1:0] :
             (hi_sh < MIN_V) ? MIN_V[DATA_W-1:0] : hi_sh[DATA_W-1:0];
  end
`else
  // Floor shift, keep the low DATA_W bits (two's-complement wrap)
  always_comb begin
    lo_out = DATA_W'(lo_sum >>> COEF_FRAC);
    hi_out = DATA_W'(hi_sum >>> COEF_FRAC);
  end
`endif
endmodule

// File: rtl/alias_reduction_ctrl.sv
// alias_reduction_ctrl: walks the subband boundaries of one granule and runs
// 8 in-place butterflies per boundary (5 cycles each: RD_LO, RD_HI, CALC,
// WR_LO, WR_HI). Outputs are decoded from state so an async reset drops them
// immediately. Optional saturation via ALIAS_SAT_EN (see alias_butterfly).
module alias_reduction_ctrl #(
  parameter int DATA_W    = alias_reduction_pkg::DATA_W,
  parameter int COEF_W    = alias_reduction_pkg::COEF_W,
  parameter int COEF_FRAC = alias_reduction_pkg::COEF_FRAC,
  parameter int ADDR_W    = alias_reduction_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     short_blk,
  input  logic                     mixed_blk,
  output logic                     busy,
  output logic                     done,
  output logic                     rom_en,
  output logic [2:0]               rom_index,
  input  logic signed [COEF_W-1:0] cs_data,
  input  logic signed [COEF_W-1:0] ca_data,
  output logic [ADDR_W-1:0]        mem_raddr,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic signed [DATA_W-1:0] mem_wdata,
  output logic                     mem_we
);
  import alias_reduction_pkg::*;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BUTTERFLIES - 1);

  state_e                   state;
  logic [SB_W-1:0]          sb, sb_last;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] lo_reg, lo_res, hi_res, lo_new, hi_new;
  logic signed [COEF_W-1:0] cs_reg, ca_reg;
  logic [ADDR_W-1:0]        lo_a, hi_a;

  assign lo_a = ADDR_W'(lo_addr(sb, idx));
  assign hi_a = ADDR_W'(hi_addr(sb, idx));

  // hi sample is consumed straight off the RAM port during CALC
  alias_butterfly #(.DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC)) u_bfly (
    .lo(lo_reg), .hi(mem_rdata), .cs(cs_reg), .ca(ca_reg),
    .lo_out(lo_new), .hi_out(hi_new)
  );

  // Sequencer state, boundary/butterfly counters and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      sb      <= '0;
      sb_last <= '0;
      idx     <= '0;
      lo_reg  <= '0;
      cs_reg  <= '0;
      ca_reg  <= '0;
      lo_res  <= '0;
      hi_res  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          sb      <= SB_W'(1);
          idx     <= '0;
          sb_last <= mixed_blk ? SB_W'(1) : SB_W'(NUM_SB - 1);
          // pure short blocks have no long-block boundaries to process
          state   <= (short_blk && !mixed_blk) ? S_DONE : S_RD_LO;
        end
        S_RD_LO: state <= S_RD_HI;
        S_RD_HI: begin
          lo_reg <= mem_rdata;
          cs_reg <= cs_data;
          ca_reg <= ca_data;
          state  <= S_CALC;
        end
        S_CALC: begin
          lo_res <= lo_new;
          hi_res <= hi_new;
          state  <= S_WR_LO;
        end
        S_WR_LO: state <= S_WR_HI;
        S_WR_HI: begin
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) sb <= sb + 1'b1;
          state <= (idx == IDX_LAST && sb == sb_last) ? S_DONE : S_RD_LO;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port decode per state; everything idles at zero
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rom_en    = 1'b0;
    rom_index = '0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (state)
      S_RD_LO: begin
        busy      = 1'b1;
        rom_en    = 1'b1;
        rom_index = idx;
        mem_raddr = lo_a;
      end
      S_RD_HI: begin
        busy      = 1'b1;
        mem_raddr = hi_a;
      end
      S_CALC:  busy = 1'b1;
      S_WR_LO: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = lo_a;
        mem_wdata = lo_res;
      end
      S_WR_HI: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = hi_a;
        mem_wdata = hi_res;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alias_reduction_ctrl.sv
// tb_alias_reduction_ctrl: directed bench with ROM/RAM models and
// hand-computed expected results.
module tb_alias_reduction_ctrl;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, short_blk = 1'b0, mixed_blk = 1'b0;
  logic busy, done, rom_en, mem_we;
  logic [2:0] rom_index;
  logic signed [17:0] cs_data = '0, ca_data = '0;
  logic [9:0] mem_raddr, mem_waddr;
  logic signed [23:0] mem_rdata = '0, mem_wdata;

  logic signed [23:0] mem [576];
  logic signed [17:0] cs_tab [8] = '{18'sd112393, 18'sd115572, 18'sd124470, 18'sd128885,
                                     18'sd130485, 18'sd130962, 18'sd131059, 18'sd131071};
  logic signed [17:0] ca_tab [8] = '{-18'sd67436, -18'sd61832, -18'sd41075, -18'sd23844,
                                     -18'sd12396, -18'sd5369, -18'sd1861, -18'sd485};
  int wr_cnt = 0, rom_cnt = 0, both_cnt = 0;
  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  alias_reduction_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .short_blk(short_blk), .mixed_blk(mixed_blk),
    .busy(busy), .done(done), .rom_en(rom_en), .rom_index(rom_index),
    .cs_data(cs_data), .ca_data(ca_data), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  // ROM (holds output when not enabled) and 1-cycle-latency sample RAM
  always @(posedge clk) begin
    mem_rdata <= mem[mem_raddr];
    if (rom_en) begin
      cs_data <= cs_tab[rom_index];
      ca_data <= ca_tab[rom_index];
      rom_cnt <= rom_cnt + 1;
    end
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (rom_en && mem_we) both_cnt <= both_cnt + 1;
  end

  task automatic fill_mem(input logic pattern);
    for (int a = 0; a < 576; a++) mem[a] = pattern ? 24'(a + 1000) : 24'sd0;
  endtask

  // Pulse start (cycle 0) and watch cycles 1..; optional re-start / async reset
  task automatic run_granule(input logic sh, input logic mx, input int restart_at,
                             input int reset_at, output int done_cyc, output int done_n,
                             output logic busy1, output logic busy_dn, output logic rst_ok);
    int last;
    done_cyc = -1; done_n = 0; busy1 = 1'b0; busy_dn = 1'b1; rst_ok = 1'b0; last = 1400;
    @(posedge clk); #1;
    short_blk = sh; mixed_blk = mx; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 1) busy1 = busy;
      if (done === 1'b1) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = n; busy_dn = busy; last = n + 4;
        end
      end
      if (n == restart_at) start = 1'b1;
      if (n == reset_at) begin
        rst_n = 1'b0;
        #1;
        rst_ok = ({busy, done, rom_en, mem_we} === 4'b0) && (rom_index === 3'd0) &&
                 (mem_raddr === 10'd0) && (mem_waddr === 10'd0) && (mem_wdata === 24'sd0);
        #2 rst_n = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    ntot++; if ({busy, done, rom_en, mem_we} !== 4'b0) $display("FAIL reset_flags got %b exp 0000", {busy, done, rom_en, mem_we}); else npass++;
    ntot++; if (rom_index !== 3'd0) $display("FAIL reset_rom_index got %0d exp 0", rom_index); else npass++;
    ntot++; if ({mem_raddr, mem_waddr} !== 20'd0) $display("FAIL reset_addr got %0d/%0d exp 0/0", mem_raddr, mem_waddr); else npass++;
    ntot++; if (mem_wdata !== 24'sd0) $display("FAIL reset_wdata got %0d exp 0", mem_wdata); else npass++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_long;
    int dc, dn, w0, r0, bad; logic b1, bd, ro;
    fill_mem(1'b0);
    mem[17] = 24'sd131072; mem[35] = -24'sd1; mem[565] = 24'sd131072;
    w0 = wr_cnt; r0 = rom_cnt;
    run_granule(1'b0, 1'b0, 0, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 1241) $display("FAIL long_done_cycle got %0d exp 1241", dc); else npass++;
    ntot++; if (dn !== 1) $display("FAIL long_done_count got %0d exp 1", dn); else npass++;
    ntot++; if (b1 !== 1'b1 || bd !== 1'b0) $display("FAIL long_busy got %b/%b exp 1/0", b1, bd); else npass++;
    ntot++; if (wr_cnt - w0 !== 496) $display("FAIL long_writes got %0d exp 496", wr_cnt - w0); else npass++;
    ntot++; if (rom_cnt - r0 !== 248) $display("FAIL long_rom_reads got %0d exp 248", rom_cnt - r0); else npass++;
    ntot++; if (mem[17] !== 24'sd112393) $display("FAIL long_addr17 got %0d exp 112393", mem[17]); else npass++;
    ntot++; if (mem[18] !== -24'sd67436) $display("FAIL long_addr18 got %0d exp -67436", mem[18]); else npass++;
    ntot++; if (mem[35] !== -24'sd1) $display("FAIL long_floor_addr35 got %0d exp -1", mem[35]); else npass++;
    ntot++; if (mem[550] !== 24'sd485) $display("FAIL long_addr550 got %0d exp 485", mem[550]); else npass++;
    ntot++; if (mem[565] !== 24'sd131071) $display("FAIL long_addr565 got %0d exp 131071", mem[565]); else npass++;
    bad = 0;
    for (int a = 0; a < 576; a++)
      if (a != 17 && a != 18 && a != 35 && a != 550 && a != 565 && mem[a] !== 24'sd0) bad++;
    ntot++; if (bad !== 0) $display("FAIL long_other_addrs got %0d nonzero exp 0", bad); else npass++;
    ntot++; if (both_cnt !== 0) $display("FAIL rom_en_with_we got %0d exp 0", both_cnt); else npass++;
  endtask

  task automatic test_mixed;
    int dc, dn, w0, r0, bad; logic b1, bd, ro;
    fill_mem(1'b1);
    mem[17] = 24'sd131072; mem[18] = 24'sd131072;
    w0 = wr_cnt; r0 = rom_cnt;
    run_granule(1'b0, 1'b1, 0, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 41) $display("FAIL mixed_done_cycle got %0d exp 41", dc); else npass++;
    ntot++; if (wr_cnt - w0 !== 16) $display("FAIL mixed_writes got %0d exp 16", wr_cnt - w0); else npass++;
    ntot++; if (rom_cnt - r0 !== 8) $display("FAIL mixed_rom_reads got %0d exp 8", rom_cnt - r0); else npass++;
    ntot++; if (mem[17] !== 24'sd179829) $display("FAIL mixed_addr17 got %0d exp 179829", mem[17]); else npass++;
    ntot++; if (mem[18] !== 24'sd44957) $display("FAIL mixed_addr18 got %0d exp 44957", mem[18]); else npass++;
    bad = 0;
    for (int a = 0; a < 576; a++)
      if ((a < 10 || a > 25) && mem[a] !== 24'(a + 1000)) bad++;
    ntot++; if (bad !== 0) $display("FAIL mixed_untouched got %0d changed exp 0", bad); else npass++;
  endtask

  task automatic test_short;
    int dc, dn, w0, r0; logic b1, bd, ro;
    w0 = wr_cnt; r0 = rom_cnt;
    run_granule(1'b1, 1'b0, 0, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 1) $display("FAIL short_done_cycle got %0d exp 1", dc); else npass++;
    ntot++; if (b1 !== 1'b0) $display("FAIL short_busy got %b exp 0", b1); else npass++;
    ntot++; if ((wr_cnt - w0) + (rom_cnt - r0) !== 0) $display("FAIL short_activity got %0d exp 0", (wr_cnt - w0) + (rom_cnt - r0)); else npass++;
    run_granule(1'b1, 1'b1, 0, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 41) $display("FAIL short_mixed_done_cycle got %0d exp 41", dc); else npass++;
  endtask

  task automatic test_saturation;
    int dc, dn; logic b1, bd, ro;
    fill_mem(1'b0);
    mem[17] = 24'sd8388607; mem[18] = 24'sd8388607;
    run_granule(1'b0, 1'b1, 0, 0, dc, dn, b1, bd, ro);
`ifdef ALIAS_SAT_EN
    ntot++; if (mem[17] !== 24'sd8388607) $display("FAIL sat_addr17 got %0d exp 8388607", mem[17]); else npass++;
`else
    ntot++; if (mem[17] !== -24'sd5268162) $display("FAIL wrap_addr17 got %0d exp -5268162", mem[17]); else npass++;
`endif
    ntot++; if (mem[18] !== 24'sd2877247) $display("FAIL sat_addr18 got %0d exp 2877247", mem[18]); else npass++;
  endtask

  task automatic test_back_to_back;
    int dc, dn, w0; logic b1, bd, ro;
    fill_mem(1'b0);
    mem[17] = 24'sd131072;
    w0 = wr_cnt;
    run_granule(1'b0, 1'b0, 100, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 1241) $display("FAIL b2b_done_cycle got %0d exp 1241", dc); else npass++;
    ntot++; if (dn !== 1) $display("FAIL b2b_done_count got %0d exp 1", dn); else npass++;
    ntot++; if (wr_cnt - w0 !== 496) $display("FAIL b2b_writes got %0d exp 496", wr_cnt - w0); else npass++;
    ntot++; if (busy !== 1'b0) $display("FAIL b2b_idle_after got %b exp 0", busy); else npass++;
    ntot++; if (mem[17] !== 24'sd112393) $display("FAIL b2b_addr17 got %0d exp 112393", mem[17]); else npass++;
  endtask

  task automatic test_reset_mid;
    int dc, dn, w0; logic b1, bd, ro;
    fill_mem(1'b0);
    mem[17] = 24'sd131072;
    w0 = wr_cnt;
    run_granule(1'b0, 1'b0, 0, 50, dc, dn, b1, bd, ro);
    ntot++; if (ro !== 1'b1) $display("FAIL midreset_outputs got %b exp 1", ro); else npass++;
    repeat (5) @(negedge clk);
    ntot++; if (wr_cnt - w0 !== 19) $display("FAIL midreset_writes got %0d exp 19", wr_cnt - w0); else npass++;
    ntot++; if ({busy, done} !== 2'b00) $display("FAIL midreset_idle got %b exp 00", {busy, done}); else npass++;
    fill_mem(1'b0);
    mem[17] = 24'sd131072; mem[565] = 24'sd131072;
    w0 = wr_cnt;
    run_granule(1'b0, 1'b0, 0, 0, dc, dn, b1, bd, ro);
    ntot++; if (dc !== 1241) $display("FAIL rerun_done_cycle got %0d exp 1241", dc); else npass++;
    ntot++; if (wr_cnt - w0 !== 496) $display("FAIL rerun_writes got %0d exp 496", wr_cnt - w0); else npass++;
    ntot++; if (mem[17] !== 24'sd112393 || mem[18] !== -24'sd67436) $display("FAIL rerun_addr17_18 got %0d/%0d exp 112393/-67436", mem[17], mem[18]); else npass++;
    ntot++; if (mem[550] !== 24'sd485 || mem[565] !== 24'sd131071) $display("FAIL rerun_addr550_565 got %0d/%0d exp 485/131071", mem[550], mem[565]); else npass++;
  endtask

  initial begin
    fill_mem(1'b0);
    test_reset;
    test_long;
    test_mixed;
    test_short;
    test_saturation;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish, %0d/%0d so far", npass, ntot);
    $fatal(1);
  end
endmodule

// File: doc/alias_reduction_ctrl.md
Name: alias_reduction_ctrl

Overview:
- Sequencer for the MP3 hybrid-synthesis alias-reduction stage.
- Walks every subband boundary of one granule's 576-sample buffer. For each boundary it runs 8 butterflies.
- Drives the index/enable of the two coefficient ROMs (cs and ca), reads sample pairs from the sample RAM, computes the butterfly, and writes both results back in place.
- Sits between requantisation/reorder and the IMDCT. It is started once per granule/channel by the frame controller.

Parameters:
- DATA_W, 24, signed sample width in the sample RAM.
- COEF_W, 18, signed coefficient width from the ROMs (Q1.17).
- COEF_FRAC, 17, fractional bits of the coefficients; shift applied after multiply.
- ADDR_W, 10, sample RAM address width (covers 0..575).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins processing when idle.
- short_blk  in  1  block_type==2; sampled at start.
- mixed_blk  in  1  mixed_block_flag; sampled at start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the granule is finished.
- rom_en  out  1  read enable to both cs and ca ROMs.
- rom_index  out  3  butterfly index i (0..7) to both ROMs.
- cs_data  in  COEF_W  cs ROM output, valid 1 cycle after rom_en.
- ca_data  in  COEF_W  ca ROM output, valid 1 cycle after rom_en.
- mem_raddr  out  ADDR_W  sample RAM read address.
- mem_rdata  in  DATA_W  sample RAM read data, 1-cycle latency.
- mem_waddr  out  ADDR_W  sample RAM write address.
- mem_wdata  out  DATA_W  sample RAM write data.
- mem_we  out  1  sample RAM write enable.

Behaviour:
- Reset values: busy=0, done=0, rom_en=0, rom_index=0, mem_raddr=0, mem_waddr=0, mem_wdata=0, mem_we=0, FSM=IDLE, counters=0.
- start is accepted only in IDLE. start while busy is ignored.
- Boundary limit on start:
  - short && !mixed → 0 boundaries.
  - mixed → 1 boundary (sb=1).
  - otherwise → 31 boundaries (sb=1..31).
- Butterfly (sb, i):
  - lo address = 18*sb-1-i; hi address = 18*sb+i.
  - lo' = (lo*cs - hi*ca) >>> COEF_FRAC
  - hi' = (hi*cs + lo*ca) >>> COEF_FRAC
  - Sums are formed at full DATA_W+COEF_W+1 width before the arithmetic shift (floor, no rounding).
- FSM states and actions:
  - IDLE: waits for start.
  - RD_LO: rom_en=1, rom_index=i, mem_raddr=lo.
  - RD_HI: mem_raddr=hi; capture mem_rdata→lo_reg, capture cs_data/ca_data.
  - CALC: capture mem_rdata→hi_reg; register lo', hi'.
  - WR_LO: mem_we=1, waddr=lo, wdata=lo'.
  - WR_HI: mem_we=1, waddr=hi, wdata=hi'; advance i, wrapping 7→0 with sb++.
  - After WR_HI: go to RD_LO if more butterflies remain, else DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
  - A zero-boundary start goes IDLE→DONE directly: no ROM or RAM activity, done one cycle after start.
- Timing: 5 cycles per butterfly.
  - Long block: done asserted 1241 cycles after start (1240 + DONE).
  - Mixed block: done after 41 cycles.
- rom_en is high only in RD_LO. mem_we is high only in WR_LO/WR_HI.
- The ROM output is held while rom_en is low.
- Reset mid-operation aborts immediately. Nothing further is written, and a partial granule is left as-is.

Optional Feature:
- ALIAS_SAT_EN defined: lo'/hi' saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Not defined: truncate to the low DATA_W bits (two's-complement wrap).

Decomposition:
- alias_reduction_pkg holds:
  - DATA_W, COEF_W, COEF_FRAC, NUM_SB=32, LINES_PER_SB=18, BUTTERFLIES=8;
  - the FSM state enum;
  - the lo/hi address functions.
- Sub-module alias_butterfly: combinational multiply/add/shift/saturate of (lo, hi, cs, ca) → (lo', hi'). The controller registers its outputs in CALC.

Test Plan:
- Long block, RAM all zero except addr17=131072, start → first writes: addr17=112393 (cs[0]), addr18=-67436 (ca[0]).
  - done exactly 1241 cycles after start; 496 total writes.
- mixed_blk=1 → writes only to addresses 10..25; done after 41 cycles; all other addresses unchanged.
- short_blk=1, mixed_blk=0 → no rom_en/mem_we activity; done 1 cycle after start.
- addr17=addr18=8388607 with i=0 coefficients:
  - with ALIAS_SAT_EN, addr17 written as 8388607;
  - without it, written as the wrapped value.
- start pulsed again at cycle 100 of a long block → ignored; done still at 1241 and only once.
- rst_n low at cycle 50 → all outputs return to reset values asynchronously; a new start runs a full, correct granule.
